// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and types for the register-file write-back arbiter.
package regfile_wb_pkg;

   localparam int REG_ID_W = 4;
   localparam int DATA_W   = 16;

   typedef struct packed {
      logic [REG_ID_W-1:0] reg_id;
      logic [DATA_W-1:0]   data;
   } wb_req_t;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_t;

   // One queued entry hazards a read when it is valid and targets the same register.
   function automatic logic id_match(input logic [REG_ID_W-1:0] slot_id,
                                     input logic [REG_ID_W-1:0] rd_id,
                                     input logic                slot_vld);
      return slot_vld & (slot_id == rd_id);
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for regfile_wb_arbiter: two write sources, the register-file write port,
// the decode-stage read IDs and the status outputs.
interface regfile_wb_arbiter_if;
   import regfile_wb_pkg::*;

   logic                a_valid;
   logic [REG_ID_W-1:0] a_reg;
   logic [DATA_W-1:0]   a_data;
   logic                a_ready;
   logic                b_valid;
   logic [REG_ID_W-1:0] b_reg;
   logic [DATA_W-1:0]   b_data;
   logic                b_ready;
   logic                wr_en;
   logic [REG_ID_W-1:0] wr_reg;
   logic [DATA_W-1:0]   wr_data;
   logic [REG_ID_W-1:0] rd_reg1;
   logic [REG_ID_W-1:0] rd_reg2;
   logic                rd_stall;
   logic                busy;

   modport master (
      output a_valid, a_reg, a_data, b_valid, b_reg, b_data, rd_reg1, rd_reg2,
      input  a_ready, b_ready, wr_en, wr_reg, wr_data, rd_stall, busy
   );

   modport slave (
      input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, rd_reg1, rd_reg2,
      output a_ready, b_ready, wr_en, wr_reg, wr_data, rd_stall, busy
   );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Per-source write-request FIFO; exposes its head, occupancy and a flattened view of
// the destination IDs of all valid slots for the read-hazard scoreboard.
module wb_fifo
   import regfile_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  wb_req_t                   push_req_i,
   input  logic                      pop_i,
   output wb_req_t                   head_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [DEPTH-1:0]          slot_vld_o,
   output logic [DEPTH*REG_ID_W-1:0] slot_reg_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   wb_req_t          mem_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_s;
   logic             pop_s;

   // Fullness is judged on the registered count, so a pop on the same edge never frees room.
   assign push_s = push_i & ~full_o;
   assign pop_s  = pop_i & ~empty_o;

   // Pointer, slot-valid and occupancy next state.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      vld_d    = vld_q;
      if (pop_s) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q    <= {DEPTH{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '{reg_id: {REG_ID_W{1'b0}}, data: {DATA_W{1'b0}}};
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= push_req_i;
      end else begin
         mem_q <= mem_q;
      end
   end

   // Flatten slot destination IDs for the scoreboard.
   always_comb begin
      slot_reg_o = {(DEPTH*REG_ID_W){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         slot_reg_o[i*REG_ID_W +: REG_ID_W] = mem_q[i].reg_id;
      end
   end

   assign head_o     = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign full_o     = (count_q == FULL_CNT);
   assign empty_o    = (count_q == {CNT_W{1'b0}});
   assign slot_vld_o = vld_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter in front of the register file's single write port.
// Define RFWB_SCOREBOARD_EN to build the read-hazard stall; otherwise rd_stall is tied low.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   regfile_wb_arbiter_if.slave bus
);

   wb_req_t                   a_req_s, b_req_s;
   wb_req_t                   a_head_s, b_head_s;
   logic [$clog2(DEPTH):0]    a_count_s, b_count_s;
   logic                      a_full_s, b_full_s;
   logic                      a_empty_s, b_empty_s;
   logic [DEPTH-1:0]          a_slot_vld_s, b_slot_vld_s;
   logic [DEPTH*REG_ID_W-1:0] a_slot_reg_s, b_slot_reg_s;
   logic                      a_push_s, b_push_s;
   logic                      pop_a_s, pop_b_s;
   logic                      stall_s;

   src_t    last_grant_q, last_grant_d;
   logic    wr_en_q, wr_en_d;
   wb_req_t wr_req_q, wr_req_d;

   assign a_req_s  = {bus.a_reg, bus.a_data};
   assign b_req_s  = {bus.b_reg, bus.b_data};
   assign a_push_s = bus.a_valid & ~a_full_s;
   assign b_push_s = bus.b_valid & ~b_full_s;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk        (clk),
      .rst        (rst),
      .push_i     (a_push_s),
      .push_req_i (a_req_s),
      .pop_i      (pop_a_s),
      .head_o     (a_head_s),
      .count_o    (a_count_s),
      .full_o     (a_full_s),
      .empty_o    (a_empty_s),
      .slot_vld_o (a_slot_vld_s),
      .slot_reg_o (a_slot_reg_s)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk        (clk),
      .rst        (rst),
      .push_i     (b_push_s),
      .push_req_i (b_req_s),
      .pop_i      (pop_b_s),
      .head_o     (b_head_s),
      .count_o    (b_count_s),
      .full_o     (b_full_s),
      .empty_o    (b_empty_s),
      .slot_vld_o (b_slot_vld_s),
      .slot_reg_o (b_slot_reg_s)
   );

   // Grant selection: a lone requester wins; on a tie the source not granted last wins.
   always_comb begin
      pop_a_s = 1'b0;
      pop_b_s = 1'b0;
      if (!a_empty_s && (b_empty_s || (last_grant_q == SRC_B))) begin
         pop_a_s = 1'b1;
      end else if (!b_empty_s) begin
         pop_b_s = 1'b1;
      end else begin
         pop_a_s = 1'b0;
         pop_b_s = 1'b0;
      end
   end

   // Output stage and grant history next state; wr_reg/wr_data hold when idle.
   always_comb begin
      last_grant_d = last_grant_q;
      wr_req_d     = wr_req_q;
      wr_en_d      = 1'b0;
      if (pop_a_s) begin
         last_grant_d = SRC_A;
         wr_req_d     = a_head_s;
         wr_en_d      = 1'b1;
      end else if (pop_b_s) begin
         last_grant_d = SRC_B;
         wr_req_d     = b_head_s;
         wr_en_d      = 1'b1;
      end else begin
         wr_en_d = 1'b0;
      end
   end

   // Output register and grant history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= SRC_B;
         wr_en_q      <= 1'b0;
         wr_req_q     <= '{reg_id: {REG_ID_W{1'b0}}, data: {DATA_W{1'b0}}};
      end else begin
         last_grant_q <= last_grant_d;
         wr_en_q      <= wr_en_d;
         wr_req_q     <= wr_req_d;
      end
   end

`ifdef RFWB_SCOREBOARD_EN
   // Output register excluded: the register file forwards DstData to a same-cycle read.
   always_comb begin
      stall_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         stall_s = stall_s
                 | id_match(a_slot_reg_s[i*REG_ID_W +: REG_ID_W], bus.rd_reg1, a_slot_vld_s[i])
                 | id_match(a_slot_reg_s[i*REG_ID_W +: REG_ID_W], bus.rd_reg2, a_slot_vld_s[i])
                 | id_match(b_slot_reg_s[i*REG_ID_W +: REG_ID_W], bus.rd_reg1, b_slot_vld_s[i])
                 | id_match(b_slot_reg_s[i*REG_ID_W +: REG_ID_W], bus.rd_reg2, b_slot_vld_s[i]);
      end
   end

   logic unused_cnt_s;
   assign unused_cnt_s = ^{a_count_s, b_count_s};
`else
   assign stall_s = 1'b0;

   logic unused_sb_s;
   assign unused_sb_s = ^{a_count_s, b_count_s, a_slot_vld_s, b_slot_vld_s,
                          a_slot_reg_s, b_slot_reg_s, bus.rd_reg1, bus.rd_reg2};
`endif

   assign bus.a_ready  = ~a_full_s;
   assign bus.b_ready  = ~b_full_s;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_reg   = wr_req_q.reg_id;
   assign bus.wr_data  = wr_req_q.data;
   assign bus.rd_stall = stall_s;
   assign bus.busy     = ~a_empty_s | ~b_empty_s | wr_en_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, hand sequences for
// reset, scoreboard and grant-history corners, and a queue scoreboard under random traffic.
module tb_regfile_wb_arbiter;
   import regfile_wb_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if bus();

   regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        av;
      logic [3:0]  ar;
      logic [15:0] ad;
      logic        bv;
      logic [3:0]  br;
      logic [15:0] bd;
      logic        ewe;
      logic [3:0]  ereg;
      logic [15:0] edata;
      logic        ear;
      logic        ebr;
      logic        ebusy;
   } vec_t;

   vec_t    vecs [19];
   wb_req_t mqa [$];
   wb_req_t mqb [$];
   wb_req_t exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                               input logic bv, input logic [3:0] br, input logic [15:0] bd,
                               input logic ewe, input logic [3:0] ereg, input logic [15:0] edata,
                               input logic ear, input logic ebr, input logic ebusy);
      vec_t v;
      v.av = av; v.ar = ar; v.ad = ad;
      v.bv = bv; v.br = br; v.bd = bd;
      v.ewe = ewe; v.ereg = ereg; v.edata = edata;
      v.ear = ear; v.ebr = ebr; v.ebusy = ebusy;
      return v;
   endfunction

   function automatic logic model_stall(input logic [3:0] r1, input logic [3:0] r2);
      logic s;
      s = 1'b0;
`ifdef RFWB_SCOREBOARD_EN
      foreach (mqa[i]) if (mqa[i].reg_id == r1 || mqa[i].reg_id == r2) s = 1'b1;
      foreach (mqb[i]) if (mqb[i].reg_id == r1 || mqb[i].reg_id == r2) s = 1'b1;
`endif
      return s;
   endfunction

   task automatic drive(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                        input logic bv, input logic [3:0] br, input logic [15:0] bd);
      bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
      bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        exp_stall_sb;
      logic        exp_ar, exp_br, pa, pb, mwe, mlast_b;
      wb_req_t     req, got;

      drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
      bus.rd_reg1 = 4'hF;
      bus.rd_reg2 = 4'hF;

`ifdef RFWB_SCOREBOARD_EN
      exp_stall_sb = 1'b1;
`else
      exp_stall_sb = 1'b0;
`endif

      // Tie: A0 B0 A1 B1 A2 B2 with B2 retried while B is full.
      vecs[0]  = mk(1'b1, 4'h1, 16'hA000, 1'b1, 4'h2, 16'hB000, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b1);
      vecs[1]  = mk(1'b1, 4'h1, 16'hA001, 1'b1, 4'h2, 16'hB001, 1'b1, 4'h1, 16'hA000, 1'b1, 1'b0, 1'b1);
      vecs[2]  = mk(1'b1, 4'h1, 16'hA002, 1'b1, 4'h2, 16'hB002, 1'b1, 4'h2, 16'hB000, 1'b0, 1'b1, 1'b1);
      vecs[3]  = mk(1'b0, 4'h0, 16'h0000, 1'b1, 4'h2, 16'hB002, 1'b1, 4'h1, 16'hA001, 1'b1, 1'b0, 1'b1);
      vecs[4]  = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h2, 16'hB001, 1'b1, 1'b1, 1'b1);
      vecs[5]  = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h1, 16'hA002, 1'b1, 1'b1, 1'b1);
      vecs[6]  = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h2, 16'hB002, 1'b1, 1'b1, 1'b1);
      vecs[7]  = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h2, 16'hB002, 1'b1, 1'b1, 1'b0);
      // Single write, then a write to register 0 passing through unchanged.
      vecs[8]  = mk(1'b1, 4'h5, 16'h1234, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h2, 16'hB002, 1'b1, 1'b1, 1'b1);
      vecs[9]  = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h5, 16'h1234, 1'b1, 1'b1, 1'b1);
      vecs[10] = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h5, 16'h1234, 1'b1, 1'b1, 1'b0);
      vecs[11] = mk(1'b1, 4'h0, 16'hFFFF, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h5, 16'h1234, 1'b1, 1'b1, 1'b1);
      vecs[12] = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
      vecs[13] = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'hFFFF, 1'b1, 1'b1, 1'b0);
      // Full FIFO: B wins the tie, A fills after 2 pushes, the third push lands on a pop edge.
      vecs[14] = mk(1'b1, 4'h3, 16'h0300, 1'b1, 4'h4, 16'h0400, 1'b0, 4'h0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
      vecs[15] = mk(1'b1, 4'h3, 16'h0301, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h4, 16'h0400, 1'b0, 1'b1, 1'b1);
      vecs[16] = mk(1'b1, 4'h3, 16'h0302, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h3, 16'h0300, 1'b1, 1'b1, 1'b1);
      vecs[17] = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h3, 16'h0301, 1'b1, 1'b1, 1'b1);
      vecs[18] = mk(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h3, 16'h0301, 1'b1, 1'b1, 1'b0);

      // Reset state.
      repeat (2) tick();
      check("rst_wr_en", bus.wr_en, 1'b0);
      check("rst_wr_reg", bus.wr_reg, 4'h0);
      check("rst_wr_data", bus.wr_data, 16'h0000);
      check("rst_a_ready", bus.a_ready, 1'b1);
      check("rst_b_ready", bus.b_ready, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_stall", bus.rd_stall, 1'b0);
      #1 rst = 1'b1;

      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
         tick();
         check($sformatf("vec%0d_wr_en", i), bus.wr_en, vecs[i].ewe);
         check($sformatf("vec%0d_wr_reg", i), bus.wr_reg, vecs[i].ereg);
         check($sformatf("vec%0d_wr_data", i), bus.wr_data, vecs[i].edata);
         check($sformatf("vec%0d_a_ready", i), bus.a_ready, vecs[i].ear);
         check($sformatf("vec%0d_b_ready", i), bus.b_ready, vecs[i].ebr);
         check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].ebusy);
         check($sformatf("vec%0d_stall", i), bus.rd_stall, 1'b0);
      end
      drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);

      // Scoreboard: a queued B write to reg 7 stalls a read of reg 7 until it pops.
      bus.rd_reg2 = 4'h7;
      drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'h7, 16'h7777);
      #1 check("sb_empty_stall", bus.rd_stall, 1'b0);
      tick();
      drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
      check("sb_queued_stall", bus.rd_stall, exp_stall_sb);
      check("sb_queued_wr_en", bus.wr_en, 1'b0);
      tick();
      check("sb_pop_wr_en", bus.wr_en, 1'b1);
      check("sb_pop_wr_reg", bus.wr_reg, 4'h7);
      check("sb_pop_stall", bus.rd_stall, 1'b0);
      bus.rd_reg2 = 4'hF;
      bus.rd_reg1 = 4'h9;
      drive(1'b1, 4'h9, 16'h9999, 1'b0, 4'h0, 16'h0000);
      tick();
      drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
      check("sb_rd1_stall", bus.rd_stall, exp_stall_sb);
      tick();
      check("sb_rd1_pop_stall", bus.rd_stall, 1'b0);
      check("sb_rd1_wr_data", bus.wr_data, 16'h9999);
      tick();

      // Reset mid-stream with both sources streaming.
      bus.rd_reg1 = 4'hA;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'hA, 16'(16'hA100 + i), 1'b1, 4'hB, 16'(16'hB100 + i));
         tick();
      end
      #2 rst = 1'b0;
      #1;
      check("mid_rst_wr_en", bus.wr_en, 1'b0);
      check("mid_rst_wr_reg", bus.wr_reg, 4'h0);
      check("mid_rst_wr_data", bus.wr_data, 16'h0000);
      check("mid_rst_a_ready", bus.a_ready, 1'b1);
      check("mid_rst_b_ready", bus.b_ready, 1'b1);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_stall", bus.rd_stall, 1'b0);
      drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
      bus.rd_reg1 = 4'hF;
      tick();
      #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("post_rst%0d_wr_en", i), bus.wr_en, 1'b0);
         check($sformatf("post_rst%0d_busy", i), bus.busy, 1'b0);
      end

      // Grant history restarts at B, so A wins the first tie.
      drive(1'b1, 4'hC, 16'h00C0, 1'b1, 4'hD, 16'h00D0);
      tick();
      drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
      check("tie_rst_idle", bus.wr_en, 1'b0);
      tick();
      check("tie_rst_first_reg", bus.wr_reg, 4'hC);
      tick();
      check("tie_rst_second_reg", bus.wr_reg, 4'hD);
      tick();
      check("tie_rst_drain", bus.wr_en, 1'b0);

      // Random traffic against a queue scoreboard; grant history is B after the last pop.
      mlast_b = 1'b1;
      mwe     = 1'b0;
      for (int c = 0; c < 300; c++) begin
         drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
               ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom));
         bus.rd_reg1 = 4'($urandom_range(0, 15));
         bus.rd_reg2 = 4'($urandom_range(0, 15));
         #1;
         exp_ar = (mqa.size() < DEPTH);
         exp_br = (mqb.size() < DEPTH);
         check("rnd_a_ready", bus.a_ready, exp_ar);
         check("rnd_b_ready", bus.b_ready, exp_br);
         check("rnd_stall", bus.rd_stall, model_stall(bus.rd_reg1, bus.rd_reg2));
         check("rnd_busy", bus.busy, (mqa.size() != 0) || (mqb.size() != 0) || mwe);
         pa = (mqa.size() != 0) && ((mqb.size() == 0) || mlast_b);
         pb = !pa && (mqb.size() != 0);
         if (pa) begin
            exp_q.push_back(mqa.pop_front());
            mlast_b = 1'b0;
         end else if (pb) begin
            exp_q.push_back(mqb.pop_front());
            mlast_b = 1'b1;
         end
         if (bus.a_valid && exp_ar) begin
            req.reg_id = bus.a_reg;
            req.data   = bus.a_data;
            mqa.push_back(req);
         end
         if (bus.b_valid && exp_br) begin
            req.reg_id = bus.b_reg;
            req.data   = bus.b_data;
            mqb.push_back(req);
         end
         mwe = pa | pb;
         tick();
         check("rnd_wr_en", bus.wr_en, mwe);
         if (bus.wr_en) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rnd_unexpected_write: got reg 0x%0h data 0x%0h, expected no write",
                        bus.wr_reg, bus.wr_data);
            end else begin
               got = exp_q.pop_front();
               if (bus.wr_reg !== got.reg_id || bus.wr_data !== got.data) begin
                  bad++;
                  $display("FAIL rnd_write: got reg 0x%0h data 0x%0h, expected reg 0x%0h data 0x%0h",
                           bus.wr_reg, bus.wr_data, got.reg_id, got.data);
               end
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
